// File: rtl/picture_loader_if.sv
// Download byte stream, RAM write port and status of the picture loader.
// The host/bench side is master; the loader is slave.
interface picture_loader_if #(
    parameter int ADDR_W = 13
);
    logic              dl_active;
    logic [7:0]        dl_data;
    logic              dl_wr;
    logic              clr_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output dl_active, dl_data, dl_wr, clr_req,
        input  ram_addr, ram_din, ram_we, busy, done, overflow, word_cnt
    );

    modport slave (
        input  dl_active, dl_data, dl_wr, clr_req,
        output ram_addr, ram_din, ram_we, busy, done, overflow, word_cnt
    );
endinterface

// File: rtl/picture_loader.sv
// Fills the 8K x 16 picture RAM from a host byte download (byte pairs packed
// low byte first) or clears it to FILL_WORD. Drives only the RAM write port.
module picture_loader #(
    parameter int          ADDR_W    = 13,
    parameter int          WORDS     = 8192,
    parameter logic [15:0] FILL_WORD = 16'h0000
) (
    input  logic             clk_ram,
    input  logic             reset_n,
    picture_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   WORDS_C     = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(WORDS - 1);

    state_t            state_r;
    logic              dl_q_r;
    logic              phase_r;
    logic [7:0]        low_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       din_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              ovf_r;
    logic [ADDR_W:0]   cnt_r;

    logic dl_rise_s;
    logic dl_fall_s;
    logic room_s;

    assign dl_rise_s = bus.dl_active & ~dl_q_r;
    assign dl_fall_s = ~bus.dl_active & dl_q_r;
    assign room_s    = (cnt_r < WORDS_C);

    assign bus.ram_addr = addr_r;
    assign bus.ram_din  = din_r;
    assign bus.ram_we   = we_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.word_cnt = cnt_r;

    // Loader state machine; every output is a register written here.
    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            dl_q_r  <= 1'b0;
            phase_r <= 1'b0;
            low_r   <= 8'h00;
            addr_r  <= '0;
            din_r   <= 16'h0000;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            dl_q_r <= bus.dl_active;
            we_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (dl_rise_s) begin
                        state_r <= ST_LOAD;
                        addr_r  <= '0;
                        cnt_r   <= '0;
                        phase_r <= 1'b0;
                        done_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (bus.clr_req) begin
                        // First fill write goes out in the first CLEAR cycle.
                        state_r <= ST_CLEAR;
                        addr_r  <= '0;
                        din_r   <= FILL_WORD;
                        we_r    <= 1'b1;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall_s) begin
                        if (phase_r && room_s) begin
                            state_r <= ST_FLUSH;
                            we_r    <= 1'b1;
                            din_r   <= {8'h00, low_r};
                            addr_r  <= cnt_r[ADDR_W-1:0];
                            cnt_r   <= cnt_r + 1'b1;
                        end else begin
                            if (phase_r) begin
                                ovf_r <= 1'b1;
                            end else begin
                                ovf_r <= ovf_r;
                            end
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else if (bus.dl_wr && bus.dl_active) begin
                        if (!phase_r) begin
                            low_r   <= bus.dl_data;
                            phase_r <= 1'b1;
                        end else begin
                            phase_r <= 1'b0;
                            if (room_s) begin
                                we_r   <= 1'b1;
                                din_r  <= {bus.dl_data, low_r};
                                addr_r <= cnt_r[ADDR_W-1:0];
                                cnt_r  <= cnt_r + 1'b1;
                            end else begin
                                ovf_r <= 1'b1;
                            end
                        end
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
                ST_CLEAR: begin
                    if (dl_rise_s) begin
                        // Download preempts the clear; the clear never completes.
                        state_r <= ST_LOAD;
                        addr_r  <= '0;
                        cnt_r   <= '0;
                        phase_r <= 1'b0;
                        done_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end else if (addr_r == LAST_ADDR_C) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        we_r   <= 1'b1;
                        addr_r <= addr_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_picture_loader.sv
// Scoreboard bench for picture_loader: expected RAM writes are queued as
// stimulus is driven and popped by a write monitor on the falling clock edge.
module tb_picture_loader;
    localparam int NW = 8192;

    logic clk_ram;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    picture_loader_if #(.ADDR_W(13)) ifc ();

    picture_loader #(.ADDR_W(13), .WORDS(NW), .FILL_WORD(16'h0000)) dut (
        .clk_ram (clk_ram),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    logic [28:0] sb_q[$];
    logic [28:0] mon_e;

    int         m_cnt;
    logic       m_phase;
    logic [7:0] m_low;
    logic       m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk_ram) begin
        if (ifc.ram_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_we", {19'd0, ifc.ram_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("wr_addr", {19'd0, ifc.ram_addr}, {19'd0, mon_e[28:16]});
                check_eq("wr_data", {16'd0, ifc.ram_din}, {16'd0, mon_e[15:0]});
            end
        end
    end

    task automatic start_load();
        ifc.dl_active = 1'b1;
        tick();
        tick();
        m_cnt = 0; m_phase = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic wr;
        wr = m_phase && (m_cnt < NW);
        if (wr) begin
            sb_q.push_back({13'(m_cnt), b, m_low});
            m_cnt++;
        end else if (m_phase) begin
            m_ovf = 1'b1;
        end
        if (!m_phase) m_low = b;
        m_phase = ~m_phase;
        ifc.dl_data = b;
        ifc.dl_wr   = 1'b1;
        tick();
        ifc.dl_wr = 1'b0;
        check_eq("we_latency", 32'(ifc.ram_we), 32'(wr));
        tick();
        check_eq("we_single", 32'(ifc.ram_we), 32'd0);
    endtask

    task automatic end_load();
        logic fl;
        fl = m_phase && (m_cnt < NW);
        if (fl) begin
            sb_q.push_back({13'(m_cnt), 8'h00, m_low});
            m_cnt++;
        end else if (m_phase) begin
            m_ovf = 1'b1;
        end
        ifc.dl_active = 1'b0;
        tick();
        check_eq("we_flush", 32'(ifc.ram_we), 32'(fl));
        tick();
        tick();
        check_eq("done_end", 32'(ifc.done), 32'd1);
        check_eq("busy_end", 32'(ifc.busy), 32'd0);
        check_eq("word_cnt", 32'(ifc.word_cnt), 32'(m_cnt));
        check_eq("overflow", 32'(ifc.overflow), 32'(m_ovf));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"},   32'(ifc.ram_we),   32'd0);
        check_eq({tag, "_addr"}, 32'(ifc.ram_addr), 32'd0);
        check_eq({tag, "_din"},  32'(ifc.ram_din),  32'd0);
        check_eq({tag, "_busy"}, 32'(ifc.busy),     32'd0);
        check_eq({tag, "_done"}, 32'(ifc.done),     32'd0);
        check_eq({tag, "_ovf"},  32'(ifc.overflow), 32'd0);
        check_eq({tag, "_cnt"},  32'(ifc.word_cnt), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_cnt = 0; m_phase = 1'b0; m_low = 8'h00; m_ovf = 1'b0;
        ifc.dl_active = 1'b0; ifc.dl_data = 8'h00; ifc.dl_wr = 1'b0; ifc.clr_req = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Two full words, write latency one cycle after the second byte
        start_load();
        check_eq("busy_load", 32'(ifc.busy), 32'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        end_load();
        tick();

        // Odd byte count flushed as {00,low}
        start_load();
        check_eq("done_cleared", 32'(ifc.done), 32'd0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        end_load();
        tick();

        // Full clear
        ifc.clr_req = 1'b1;
        tick();
        ifc.clr_req = 1'b0;
        check_eq("clr_done_low", 32'(ifc.done), 32'd0);
        for (int i = 0; i < NW; i++) begin
            sb_q.push_back({13'(i), 16'h0000});
            check_eq("clr_we", 32'(ifc.ram_we), 32'd1);
            check_eq("clr_busy", 32'(ifc.busy), 32'd1);
            tick();
        end
        check_eq("clr_we_end", 32'(ifc.ram_we), 32'd0);
        check_eq("clr_done", 32'(ifc.done), 32'd1);
        check_eq("clr_busy_end", 32'(ifc.busy), 32'd0);
        check_eq("clr_cnt_kept", 32'(ifc.word_cnt), 32'd2);
        tick(); tick();

        // Clear aborted by a download at clear cycle 100
        ifc.clr_req = 1'b1;
        tick();
        ifc.clr_req = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            sb_q.push_back({13'(i), 16'h0000});
            if (i == 100) ifc.dl_active = 1'b1;
            tick();
        end
        check_eq("abort_we", 32'(ifc.ram_we), 32'd0);
        check_eq("abort_done", 32'(ifc.done), 32'd0);
        check_eq("abort_busy", 32'(ifc.busy), 32'd1);
        tick();
        check_eq("abort_we2", 32'(ifc.ram_we), 32'd0);
        m_cnt = 0; m_phase = 1'b0; m_ovf = 1'b0;
        send_byte(8'h5A); send_byte(8'hC3);
        end_load();
        tick();

        // Overflow: 16386 bytes, last pair dropped
        start_load();
        for (int i = 0; i < 2 * NW + 2; i++) send_byte(8'($urandom_range(0, 255)));
        end_load();
        check_eq("ovf_sticky", 32'(ifc.overflow), 32'd1);
        tick();

        // Reset in the middle of a load
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
        send_byte(8'h99);
        reset_n = 1'b0;
        ifc.dl_active = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_no_we", 32'(ifc.ram_we), 32'd0);
        end
        start_load();
        send_byte(8'h01); send_byte(8'h02);
        end_load();
        tick();

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
